// File: rtl/ofmap_wb_pkg.sv
// ofmap_wb_pkg
// Shared sizing globals and types for the output write-back stage.
//   N       activation bit width per lane
//   W       lanes per word (data word is N*W bits, lane 0 in the MSBs)
//   CLOG2M  log2 of rows per bank
//   CLOG2W  log2 of lanes per word
//   AW      bank address width
//   wb_entry_t  one queued write: bank, address, data, per-lane byte enable
//   BE_UPPER / BE_LOWER  lane masks of the upper (lanes 0..W/2-1) and lower halves
package ofmap_wb_pkg;

    localparam int N      = 4;
    localparam int W      = 8;
    localparam int CLOG2M = 4;
    localparam int CLOG2W = 3;
    localparam int AW     = CLOG2M + CLOG2W;
    localparam int DW     = N * W;

    typedef struct packed {
        logic          bank;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [W-1:0]  be;
    } wb_entry_t;

    // be bit W-1 maps to lane 0, so the "upper" half (lanes 0..W/2-1) is the top bits.
    localparam logic [W-1:0] BE_UPPER = {{(W/2){1'b1}}, {(W/2){1'b0}}};
    localparam logic [W-1:0] BE_LOWER = ~BE_UPPER;

endpackage

// File: rtl/ofmap_wb_fifo.sv
// wb_fifo
// Small synchronous FIFO of wb_entry_t with two push ports and occupancy count.
//   ck, rst_n          clock, asynchronous active-low reset
//   push0/din0         older push of this cycle
//   push1/din1         younger push of this cycle
//   pop                remove head (ignored when empty)
//   head, valid        current head entry (zero when empty) and non-empty flag
//   count, count_next  occupancy now and after this cycle
//   drop               a push was refused for lack of space this cycle
module wb_fifo
    import ofmap_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     ck,
    input  logic                     rst_n,
    input  logic                     push0,
    input  wb_entry_t                din0,
    input  logic                     push1,
    input  wb_entry_t                din1,
    input  logic                     pop,
    output wb_entry_t                head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_next,
    output logic                     drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            pop_ok;
    logic            acc0;
    logic            acc1;
    logic [CW:0]     free;

    always_comb begin
        pop_ok = pop & (count_reg != '0);
        // An entry leaving this cycle frees its slot for a same-cycle push,
        // which is what lets push and pop coexist at full.
        free   = (CW+1)'(DEPTH) - {1'b0, count_reg} + (CW+1)'(pop_ok);
        // The older push gets space first; overflow drops the younger beat.
        acc0   = push0 & (free >= (CW+1)'(1));
        acc1   = push1 & (free >= ((CW+1)'(acc0) + (CW+1)'(1)));
        drop   = (push0 & ~acc0) | (push1 & ~acc1);
        count_next = count_reg + CW'(acc0) + CW'(acc1) - CW'(pop_ok);
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            wr_ptr_reg <= wr_ptr_reg + PW'(acc0) + PW'(acc1);
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: the count gates every use of it.
    always_ff @(posedge ck) begin
        if (acc0)
            mem[wr_ptr_reg] <= din0;
        if (acc1)
            mem[wr_ptr_reg + PW'(acc0)] <= din1;
    end

    assign valid = (count_reg != '0);
    assign head  = valid ? mem[rd_ptr_reg] : '0;
    assign count = count_reg;

endmodule

// File: rtl/ofmap_wb.sv
// ofmap_wb
// Output write-back stage: merges half-word result beats into full words,
// queues them and issues lane-masked writes to the even/odd result SRAM.
//   ck, rst_n                       clock, asynchronous active-low reset
//   i_wr, i_wrh, i_wrh_l_n          beat valid, half-beat flag, lower-half flag
//   i_ev_odd_n                      bank select (1 = odd)
//   i_even_addr, i_odd_addr, i_data beat address candidates and data
//   i_flush                         push out any pending half word
//   o_stall                         registered: FIFO nearly full, hold the pipe
//   o_idle                          nothing pending, queued or outstanding
//   o_ovf                           sticky: a beat was dropped
//   m_valid/m_ready, m_bank, m_addr, m_data, m_be   SRAM write request port
module ofmap_wb
    import ofmap_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          i_wr,
    input  logic          i_wrh,
    input  logic          i_wrh_l_n,
    input  logic          i_ev_odd_n,
    input  logic [AW-1:0] i_even_addr,
    input  logic [AW-1:0] i_odd_addr,
    input  logic [DW-1:0] i_data,
    input  logic          i_flush,
    output logic          o_stall,
    output logic          o_idle,
    output logic          o_ovf,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_bank,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_data,
    output logic [W-1:0]  m_be
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t      pend_reg;
    wb_entry_t      pend_next;
    logic           pend_valid_reg;
    logic           pend_valid_next;
    wb_entry_t      beat;
    wb_entry_t      merged;
    logic [DW-1:0]  merged_data;
    logic           same_slot;
    logic           push0;
    logic           push1;
    wb_entry_t      push0_entry;
    wb_entry_t      push1_entry;
    wb_entry_t      head;
    logic           fifo_valid;
    logic           drop;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_next;
    logic           ovf_reg;
    logic           stall_reg;

    // Lane-wise merge: lanes owned by the pending half come from it, the rest
    // from the incoming opposite half.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_merge
            assign merged_data[gi*N +: N] = pend_reg.be[gi] ? pend_reg.data[gi*N +: N]
                                                            : i_data[gi*N +: N];
        end
    endgenerate

    always_comb begin
        beat.bank = i_ev_odd_n;
        beat.addr = i_ev_odd_n ? i_odd_addr : i_even_addr;
        beat.data = i_data;
        beat.be   = i_wrh ? (i_wrh_l_n ? BE_LOWER : BE_UPPER) : '1;

        merged      = beat;
        merged.data = merged_data;
        merged.be   = '1;

        // Halves carry one of two masks, so a differing mask means the opposite half.
        same_slot = (pend_reg.bank == beat.bank) && (pend_reg.addr == beat.addr)
                    && (pend_reg.be != beat.be);
    end

    always_comb begin
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        push0           = 1'b0;
        push1           = 1'b0;
        push0_entry     = '0;
        push1_entry     = '0;

        if (i_wr) begin
            if (!i_wrh) begin
                if (pend_valid_reg) begin
                    push0       = 1'b1;
                    push0_entry = pend_reg;
                    push1       = 1'b1;
                    push1_entry = beat;
                end else begin
                    push0       = 1'b1;
                    push0_entry = beat;
                end
                pend_valid_next = 1'b0;
            end else if (!pend_valid_reg) begin
                pend_next       = beat;
                pend_valid_next = 1'b1;
            end else if (same_slot) begin
                push0           = 1'b1;
                push0_entry     = merged;
                pend_valid_next = 1'b0;
            end else begin
                push0           = 1'b1;
                push0_entry     = pend_reg;
                pend_next       = beat;
                pend_valid_next = 1'b1;
            end
        end

        // Flush acts on whatever is pending after the beat, so it can follow
        // a beat push in the same cycle; at most two pushes ever result.
        if (i_flush && pend_valid_next) begin
            if (push0) begin
                push1       = 1'b1;
                push1_entry = pend_next;
            end else begin
                push0       = 1'b1;
                push0_entry = pend_next;
            end
            pend_valid_next = 1'b0;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .ck         (ck),
        .rst_n      (rst_n),
        .push0      (push0),
        .din0       (push0_entry),
        .push1      (push1),
        .din1       (push1_entry),
        .pop        (m_ready),
        .head       (head),
        .valid      (fifo_valid),
        .count      (count),
        .count_next (count_next),
        .drop       (drop)
    );

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            ovf_reg        <= 1'b0;
            stall_reg      <= 1'b0;
        end else begin
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            ovf_reg        <= ovf_reg | drop;
            // Registered from the next count so it tracks the current occupancy.
            stall_reg      <= (count_next >= CW'(DEPTH - 2));
        end
    end

    assign o_stall = stall_reg;
    assign o_ovf   = ovf_reg;
    assign o_idle  = ~pend_valid_reg & (count == '0);
    assign m_valid = fifo_valid;
    assign m_bank  = head.bank;
    assign m_addr  = head.addr;
    assign m_data  = head.data;
    assign m_be    = head.be;

endmodule
